// File: rtl/ir_nec_transmit.sv
// NEC-protocol IR transmitter.
// Sends a leader (16-unit mark, 8-unit space), 32 data bits LSB-first
// (1-unit mark, then a 1-unit space for a 0 or a 3-unit space for a 1)
// and a 1-unit stop mark. After that it waits GAP_UNITS idle units.
// Two outputs are provided: a carrier-modulated LED drive and an active-low
// envelope. The envelope can be looped straight into an NEC receiver.
// Every output is registered. Each output's next value is derived from the
// FSM's next state, so the outputs line up with the state they describe.
module ir_nec_transmit #(
  parameter int UNIT_CYC    = 28125,
  parameter int CARRIER_EN  = 1,
  parameter int CARRIER_DIV = 1316,
  parameter int GAP_UNITS   = 72,
  parameter int AUTO_INV    = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        iSTART,
  input  logic [31:0] iDATA,
  output logic        oREADY,
  output logic        oDONE,
  output logic        oIRDA_TXD,
  output logic        oENV_N
);

  // Counter widths
  localparam int CYC_W    = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int UNIT_MAX = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int UNIT_W   = $clog2(UNIT_MAX + 1);
  localparam int CAR_W    = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  // Terminal counts. Unit counts are stored as "last index", i.e. duration - 1.
  localparam logic [CYC_W-1:0]  CYC_LAST        = CYC_W'(UNIT_CYC - 1);
  localparam logic [UNIT_W-1:0] LEAD_MARK_LAST  = UNIT_W'(15);
  localparam logic [UNIT_W-1:0] LEAD_SPACE_LAST = UNIT_W'(7);
  localparam logic [UNIT_W-1:0] ONE_UNIT_LAST   = UNIT_W'(0);
  localparam logic [UNIT_W-1:0] THREE_UNIT_LAST = UNIT_W'(2);
  localparam logic [UNIT_W-1:0] GAP_LAST        = UNIT_W'(GAP_UNITS - 1);
  localparam logic [CAR_W-1:0]  CAR_LAST        = CAR_W'(CARRIER_DIV - 1);
  localparam logic [CAR_W-1:0]  CAR_HALF        = CAR_W'(CARRIER_DIV / 2);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } state_t;

  state_t              state_reg, state_next;
  logic [CYC_W-1:0]    cyc_reg, cyc_next;
  logic [UNIT_W-1:0]   unit_reg, unit_next;
  logic [4:0]          bit_reg, bit_next;
  logic [31:0]         shift_reg, shift_next;
  logic [CAR_W-1:0]    car_reg, car_next;

  logic                ready_reg, ready_next;
  logic                done_reg, done_next;
  logic                txd_reg, txd_next;
  logic                env_n_reg, env_n_next;

  logic [UNIT_W-1:0]   unit_last;
  logic                unit_done;
  logic                state_done;
  logic                mark_next;
  logic                mark_start;
  logic [31:0]         load_word;

  // Word captured on accept. With AUTO_INV, byte 3 is rebuilt from the key code.
  assign load_word = (AUTO_INV != 0) ? {~iDATA[23:16], iDATA[23:0]} : iDATA;

  // Next-state, counter and registered-output logic
  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    unit_next  = unit_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    unit_last  = ONE_UNIT_LAST;

    case (state_reg)
      LEAD_MARK:  unit_last = LEAD_MARK_LAST;
      LEAD_SPACE: unit_last = LEAD_SPACE_LAST;
      BIT_SPACE:  unit_last = shift_reg[0] ? THREE_UNIT_LAST : ONE_UNIT_LAST;
      GAP:        unit_last = GAP_LAST;
      default:    unit_last = ONE_UNIT_LAST;
    endcase

    unit_done  = (cyc_reg == CYC_LAST);
    state_done = unit_done && (unit_reg == unit_last);

    if (state_reg == IDLE) begin
      // oREADY is high exactly while in IDLE, so this is the accept condition.
      if (iSTART) begin
        state_next = LEAD_MARK;
        shift_next = load_word;
        bit_next   = '0;
        cyc_next   = '0;
        unit_next  = '0;
      end
    end else if (state_done) begin
      cyc_next  = '0;
      unit_next = '0;
      case (state_reg)
        LEAD_MARK:  state_next = LEAD_SPACE;
        LEAD_SPACE: state_next = BIT_MARK;
        BIT_MARK:   state_next = BIT_SPACE;
        BIT_SPACE: begin
          // Bit index wraps 31 -> 0 on the way out to the stop mark.
          shift_next = {1'b0, shift_reg[31:1]};
          bit_next   = bit_reg + 5'd1;
          state_next = (bit_reg == 5'd31) ? STOP_MARK : BIT_MARK;
        end
        STOP_MARK:  state_next = GAP;
        GAP:        state_next = IDLE;
        default:    state_next = IDLE;
      endcase
    end else if (unit_done) begin
      cyc_next  = '0;
      unit_next = unit_reg + UNIT_W'(1);
    end else begin
      cyc_next = cyc_reg + CYC_W'(1);
    end

    mark_next  = (state_next == LEAD_MARK) || (state_next == BIT_MARK) ||
                 (state_next == STOP_MARK);
    // No mark follows another mark directly, so a state change into a mark
    // is always the first cycle of that mark.
    mark_start = mark_next && (state_next != state_reg);

    car_next = '0;
    if (mark_next && !mark_start) begin
      car_next = (car_reg == CAR_LAST) ? '0 : car_reg + CAR_W'(1);
    end

    ready_next = (state_next == IDLE);
    done_next  = (state_reg == STOP_MARK) && (state_next == GAP);
    env_n_next = !mark_next;
    txd_next   = mark_next && ((CARRIER_EN == 0) || (car_next < CAR_HALF));
  end

  // FSM state, timing counters and data shift register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cyc_reg   <= '0;
      unit_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      car_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      unit_reg  <= unit_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      car_reg   <= car_next;
    end
  end

  // Registered outputs
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
      txd_reg   <= 1'b0;
      env_n_reg <= 1'b1;
    end else begin
      ready_reg <= ready_next;
      done_reg  <= done_next;
      txd_reg   <= txd_next;
      env_n_reg <= env_n_next;
    end
  end

  assign oREADY    = ready_reg;
  assign oDONE     = done_reg;
  assign oIRDA_TXD = txd_reg;
  assign oENV_N    = env_n_reg;

endmodule

// File: tb/tb_ir_nec_transmit.sv
// Testbench for ir_nec_transmit.
// Instance 0 uses UNIT_CYC=4, GAP_UNITS=2, CARRIER_EN=0 and AUTO_INV=0.
// Instance 1 uses UNIT_CYC=8, CARRIER_DIV=4, CARRIER_EN=1 and AUTO_INV=1.
// The stimulus pushes the expected word and frame length into a per-instance
// queue. A monitor decodes each frame from the envelope. On oDONE it pops the
// queue and compares the word, the frame length, the waveform shape, the
// carrier and the gap back to oREADY.
module tb_ir_nec_transmit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  start = 2'b00;
  logic [31:0] data0 = 32'h0;
  logic [31:0] data1 = 32'h0;
  wire  [1:0]  ready, done, txd, env_n;

  always #5 clk = ~clk;

  ir_nec_transmit #(.UNIT_CYC(4), .CARRIER_EN(0), .CARRIER_DIV(4),
                    .GAP_UNITS(2), .AUTO_INV(0)) dut (
    .CLOCK_50(clk), .reset(rst), .iSTART(start[0]), .iDATA(data0),
    .oREADY(ready[0]), .oDONE(done[0]), .oIRDA_TXD(txd[0]), .oENV_N(env_n[0])
  );

  ir_nec_transmit #(.UNIT_CYC(8), .CARRIER_EN(1), .CARRIER_DIV(4),
                    .GAP_UNITS(2), .AUTO_INV(1)) dut_car (
    .CLOCK_50(clk), .reset(rst), .iSTART(start[1]), .iDATA(data1),
    .oREADY(ready[1]), .oDONE(done[1]), .oIRDA_TXD(txd[1]), .oENV_N(env_n[1])
  );

  typedef struct {
    logic [31:0] word;
    int          cycles;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor state, one slot per instance
  logic in_frame [2];
  logic waitr    [2];
  logic cur      [2];
  logic start_lvl[2];
  int   cnt      [2];
  int   run      [2];
  int   nruns    [2];
  int   wcnt     [2];
  int   car_err  [2];
  int   runs     [2][80];

  task automatic check_txd(input int k);
    logic exp_txd;
    if (env_n[k] == 1'b0)
      exp_txd = (k == 1) ? (((run[k] - 1) % 4) < 2) : 1'b1;
    else
      exp_txd = 1'b0;
    if (txd[k] !== exp_txd) car_err[k]++;
  endtask

  task automatic finish_frame(input int k);
    int          u;
    int          shape;
    logic [31:0] w;
    exp_t        e;
    u = (k == 0) ? 4 : 8;
    shape = 0;
    w = 32'h0;
    if (start_lvl[k] != 1'b0) shape++;
    if (nruns[k] != 67) begin
      shape++;
    end else begin
      if (runs[k][0] != 16 * u) shape++;
      if (runs[k][1] != 8 * u) shape++;
      for (int i = 0; i < 32; i++) begin
        if (runs[k][2 + 2 * i] != u) shape++;
        if (runs[k][3 + 2 * i] == 3 * u) w[i] = 1'b1;
        else if (runs[k][3 + 2 * i] != u) shape++;
      end
      if (runs[k][66] != u) shape++;
    end
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      chk($sformatf("unexpected_frame%0d", k), 1, 0);
    end else begin
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("word%0d", k), w, e.word);
      chk($sformatf("frame_len%0d", k), cnt[k] - 1, e.cycles);
      chk($sformatf("shape_errs%0d", k), shape, 0);
      chk($sformatf("carrier_errs%0d", k), car_err[k], 0);
    end
    in_frame[k] = 1'b0;
    waitr[k] = 1'b1;
    wcnt[k] = 0;
  endtask

  task automatic monitor_step(input int k);
    if (!in_frame[k] && done[k] === 1'b1)
      chk($sformatf("stray_done%0d", k), 1, 0);
    if (in_frame[k]) begin
      cnt[k]++;
      if (env_n[k] == cur[k]) begin
        run[k]++;
      end else begin
        if (nruns[k] < 80) runs[k][nruns[k]] = run[k];
        nruns[k]++;
        cur[k] = env_n[k];
        run[k] = 1;
      end
      check_txd(k);
      if (done[k] === 1'b1) finish_frame(k);
      else if (cnt[k] > 3000) begin
        chk($sformatf("frame_timeout%0d", k), cnt[k], 0);
        in_frame[k] = 1'b0;
      end
    end else if (waitr[k]) begin
      wcnt[k]++;
      if (ready[k] === 1'b1) begin
        chk($sformatf("ready_gap%0d", k), wcnt[k], (k == 0) ? 8 : 16);
        waitr[k] = 1'b0;
      end else if (wcnt[k] > 500) begin
        chk($sformatf("ready_timeout%0d", k), wcnt[k], (k == 0) ? 8 : 16);
        waitr[k] = 1'b0;
      end
    end else if (ready[k] === 1'b0) begin
      in_frame[k] = 1'b1;
      cnt[k] = 1;
      nruns[k] = 0;
      cur[k] = env_n[k];
      start_lvl[k] = env_n[k];
      run[k] = 1;
      car_err[k] = 0;
      check_txd(k);
    end
  endtask

  // Monitor: decodes both transmitters on the falling edge
  initial begin
    for (int k = 0; k < 2; k++) begin
      in_frame[k] = 1'b0;
      waitr[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          in_frame[k] = 1'b0;
          waitr[k] = 1'b0;
        end else begin
          monitor_step(k);
        end
      end
    end
  end

  task automatic wait_ready(input int k);
    int t;
    t = 0;
    @(negedge clk);
    while (ready[k] !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk($sformatf("wait_ready_timeout%0d", k), 0, 1);
  endtask

  task automatic send(input int k, input logic [31:0] word, input bit push,
                      input logic [31:0] exp_word, input int exp_cycles);
    exp_t e;
    wait_ready(k);
    e.word = exp_word;
    e.cycles = exp_cycles;
    if (push) begin
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    if (k == 0) data0 = word;
    else data1 = word;
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    chk($sformatf("accept_ready%0d", k), ready[k], 0);
    chk($sformatf("accept_env%0d", k), env_n[k], 0);
    start[k] = 1'b0;
    // Scramble the input word: the frame in flight must not change.
    if (k == 0) data0 = $urandom;
    else data1 = $urandom;
  endtask

  // Stimulus
  initial begin
    int t;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready[0], 1);
    chk("rst_done", done[0], 0);
    chk("rst_txd", txd[0], 0);
    chk("rst_env", env_n[0], 1);

    send(0, 32'h0000_0000, 1'b1, 32'h0000_0000, 356);
    send(0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 612);
    send(0, 32'h8000_0001, 1'b1, 32'h8000_0001, 372);

    // A start pulse with new data in a data space must be ignored and not queued
    send(0, 32'hA5C3_0F1E, 1'b1, 32'hA5C3_0F1E, 484);
    repeat (100) @(negedge clk);
    t = 0;
    while (env_n[0] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    start[0] = 1'b1;
    data0 = 32'hFFFF_FFFF;
    @(negedge clk);
    start[0] = 1'b0;
    wait_ready(0);
    repeat (20) @(negedge clk);
    chk("no_queued_start", ready[0], 1);

    // Reset in the middle of a frame; that frame is abandoned
    send(0, 32'h1234_5678, 1'b0, 32'h0, 0);
    repeat (200) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_ready", ready[0], 1);
    chk("midrst_done", done[0], 0);
    chk("midrst_txd", txd[0], 0);
    chk("midrst_env", env_n[0], 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(0, 32'h001A_FF00, 1'b1, 32'h001A_FF00, 444);

    // Carrier and auto-inverted byte 3 on the second instance
    send(1, 32'h771A_FF00, 1'b1, 32'hE51A_FF00, 968);

    t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || waitr[0] || waitr[1]) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("queue0_left", q0.size(), 0);
    chk("queue1_left", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
